ram_512x32: RTL and testbench

//   Single-port word-addressed memory for the processor: instructions and data.

---
 rtl/ram_512x32.sv | 54 +++++
 tb/tb_ram_512x32.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_512x32.sv
// Single-port 512x32 word memory: synchronous write, combinational gated read.
// Define RAM_WR_BYPASS_EN to make a same-cycle read return the word being written.
module ram_512x32 #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       addr_ext;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Out-of-range addresses are rejected outright rather than folded onto a valid word.
  assign addr_ext = 32'(addr);
  assign in_range = (addr_ext < DEPTH);
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr && in_range) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && !reset && in_range) begin
`ifdef RAM_WR_BYPASS_EN
      if (wr) begin
        rdata = wdata;
      end else begin
        rdata = mem[idx];
      end
`else
      rdata = mem[idx];
`endif
    end
  end

endmodule

// File: tb/tb_ram_512x32.sv
// Directed bench for ram_512x32: table of pre-edge read checks plus reset,
// read-gating and same-address read/write sequences.
module tb_ram_512x32;

  logic        clock;
  logic        reset;
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] rdata;

  int n_vec;
  int n_err;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

`ifdef RAM_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ram_512x32 dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .wr    (wr),
    .wdata (wdata),
    .rd    (rd),
    .rdata (rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    n_vec++;
    if (rdata !== exp) begin
      n_err++;
      $display("FAIL %s: rdata=%h expected=%h", name, rdata, exp);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic read_at(input string name, input logic [8:0] a, input logic [31:0] exp);
    wr = 1'b0; rd = 1'b1; addr = a;
    #1;
    check(name, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; wr = 1'b0; rd = 1'b1; addr = 9'd3; wdata = 32'hFFFF_FFFF;

    // program load with rd low, then readback in the same cycle as addr
    add(1, 0, 9'd0, 32'h10F0_0010, 32'h0);
    add(1, 0, 9'd1, 32'h2001_0000, 32'h0);
    add(1, 0, 9'd2, 32'h2123_0000, 32'h0);
    add(1, 0, 9'd3, 32'h2245_0000, 32'h0);
    add(1, 0, 9'd4, 32'h2367_0000, 32'h0);
    add(0, 1, 9'd0, 32'h0, 32'h10F0_0010);
    add(0, 1, 9'd1, 32'h0, 32'h2001_0000);
    add(0, 1, 9'd2, 32'h0, 32'h2123_0000);
    add(0, 1, 9'd3, 32'h0, 32'h2245_0000);
    add(0, 1, 9'd4, 32'h0, 32'h2367_0000);
    add(1, 1, 9'd6, 32'h1111_1111, BYPASS ? 32'h1111_1111 : 32'h0);
    add(0, 1, 9'd6, 32'h0, 32'h1111_1111);
    add(1, 0, 9'd511, 32'hA5A5_A5A5, 32'h0);
    add(1, 0, 9'd0, 32'h5A5A_5A5A, 32'h0);
    add(0, 1, 9'd511, 32'h0, 32'hA5A5_A5A5);
    add(0, 1, 9'd0, 32'h0, 32'h5A5A_5A5A);
    add(0, 1, 9'd510, 32'h0, 32'h0);
    add(0, 1, 9'd1, 32'h0, 32'h2001_0000);
    add(0, 0, 9'd511, 32'h0, 32'h0);

    #2;
    check("reset_rd_high", 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("post_reset_word3", 32'h0);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      wr = tbl[i].wr; rd = tbl[i].rd; addr = tbl[i].addr; wdata = tbl[i].wdata;
      #2;
      check($sformatf("vec%0d_addr%0d", i, tbl[i].addr), tbl[i].exp);
      tick();
    end

    // read gating: rd toggles with no clock edge between
    wr = 1'b0; rd = 1'b0; addr = 9'd1;
    #1;
    check("gate_rd_low", 32'h0);
    rd = 1'b1;
    #1;
    check("gate_rd_high", 32'h2001_0000);
    tick();

    // same-address read and write
    addr = 9'd5; rd = 1'b1; wr = 1'b1; wdata = 32'hDEAD_BEEF;
    #2;
    check("same_addr_before_edge", BYPASS ? 32'hDEAD_BEEF : 32'h0);
    tick();
    wr = 1'b0;
    #1;
    check("same_addr_after_edge", 32'hDEAD_BEEF);
    tick();

    // mid-sim reset: rdata forced low while reset is high, contents gone afterwards
    #1;
    reset = 1'b1;
    #1;
    read_at("in_reset_addr0", 9'd0, 32'h0);
    read_at("in_reset_addr511", 9'd511, 32'h0);
    wr = 1'b1; wdata = 32'h1234_5678; addr = 9'd2;
    #1;
    check("in_reset_rd_wr", 32'h0);
    tick();
    wr = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    read_at("after_reset_addr0", 9'd0, 32'h0);
    read_at("after_reset_addr1", 9'd1, 32'h0);
    read_at("after_reset_addr2", 9'd2, 32'h0);
    read_at("after_reset_addr4", 9'd4, 32'h0);
    read_at("after_reset_addr5", 9'd5, 32'h0);
    read_at("after_reset_addr511", 9'd511, 32'h0);
    tick();

    // async reset pulse between edges while a write is pending
    addr = 9'd7; wdata = 32'hCAFE_F00D; wr = 1'b1; rd = 1'b0;
    tick();
    wr = 1'b1; addr = 9'd8; wdata = 32'h0BAD_F00D;
    #1;
    reset = 1'b1;
    tick();
    wr = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    read_at("rst_pulse_addr7", 9'd7, 32'h0);
    read_at("rst_pulse_addr8", 9'd8, 32'h0);

    // first write after release lands at the next edge
    wr = 1'b1; rd = 1'b0; addr = 9'd9; wdata = 32'h0000_0009;
    tick();
    read_at("first_write_after_release", 9'd9, 32'h0000_0009);
    tick();
    read_at("static_hold_addr9", 9'd9, 32'h0000_0009);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
